// File: rtl/tinsel_msg_redirect_accel_pkg.sv
// Shared NoC types for the Tinsel message redirect accelerator.
package tinsel_accel_pkg;

    localparam int unsigned MESH_X_BITS   = 4;
    localparam int unsigned MESH_Y_BITS   = 4;
    localparam int unsigned BITS_PER_FLIT = 128;

    typedef struct packed {
        logic [MESH_Y_BITS-1:0] board_y;
        logic [MESH_X_BITS-1:0] board_x;
        logic [7:0]             core_thread;
    } NetAddr;

    typedef struct packed {
        NetAddr                   dest;
        logic [BITS_PER_FLIT-1:0] payload;
        logic                     not_final_flit;
        logic                     is_idle_token;
    } Flit;

    localparam int unsigned FLIT_BITS    = $bits(Flit);
    localparam int unsigned NETADDR_BITS = $bits(NetAddr);

    typedef enum logic {
        HEAD,
        BODY
    } state_t;

endpackage

// File: rtl/tinsel_msg_redirect_accel_fifo.sv
// Registered flit FIFO; power-of-two depth, no fall-through, negedge-clocked.
module tinsel_flit_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(negedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tinsel_msg_redirect_accel.sv
// Multi-flit message redirect accelerator: buffers flits, rewrites the
// destination of every flit of a message from its head payload, counts messages.
module tinsel_msg_redirect_accel
    import tinsel_accel_pkg::*;
#(
    parameter int unsigned TILE_X     = 0,
    parameter int unsigned TILE_Y     = 0,
    parameter int unsigned IN_DEPTH   = 4,
    parameter int unsigned DEST_LSB   = 0,
    parameter int unsigned COUNT_BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [MESH_X_BITS-1:0] board_x,
    input  logic [MESH_Y_BITS-1:0] board_y,
    input  logic [FLIT_BITS-1:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [FLIT_BITS-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COUNT_BITS-1:0]  msg_count,
    output logic                   busy
);

    localparam int unsigned CW = $clog2(IN_DEPTH) + 1;

    logic [FLIT_BITS-1:0] fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic                 load;
    state_t               state;
    NetAddr               held_dest;
    NetAddr               head_dest;
    Flit                  head;
    Flit                  next_flit;
    Flit                  out_reg;
    logic                 unused_bits;

    assign unused_bits = ^{board_x, board_y, TILE_X[0], TILE_Y[0]};

    assign in_ready  = (fifo_count != CW'(IN_DEPTH));
    assign load      = !fifo_empty && (!out_valid || out_ready);
    assign head      = fifo_rd_data;
    assign out_data  = out_reg;
    assign busy      = !fifo_empty || out_valid || (state == BODY);

    tinsel_flit_fifo #(
        .WIDTH (FLIT_BITS),
        .DEPTH (IN_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid && !fifo_full),
        .wr_data (in_data),
        .pop     (load),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Rewrite the popped flit: heads take their own payload field, bodies the held one.
    always_comb begin
        head_dest = head.payload[DEST_LSB +: NETADDR_BITS];
        next_flit = head;
        if (!head.is_idle_token)
            next_flit.dest = (state == HEAD) ? head_dest : held_dest;
    end

    // Framing state machine, output register and message counter, all advanced on a load.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HEAD;
            held_dest <= '0;
            out_reg   <= '0;
            out_valid <= 1'b0;
            msg_count <= '0;
        end else if (load) begin
            out_reg   <= next_flit;
            out_valid <= 1'b1;
            if (!head.is_idle_token) begin
                if (state == HEAD) begin
                    if (head.not_final_flit) begin
                        held_dest <= head_dest;
                        state     <= BODY;
                    end else begin
                        msg_count <= msg_count + 1'b1;
                    end
                end else if (!head.not_final_flit) begin
                    msg_count <= msg_count + 1'b1;
                    state     <= HEAD;
                end
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
